// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock divider and its decade stages.
package clk_div_pkg;

  // Divisor loaded at reset: 50 MHz reference down to 1 Hz.
  localparam int unsigned DIV_DEFAULT = 50_000_000;

  // Modulus and counter width of one decade stage.
  localparam int unsigned DEC_MOD = 10;
  localparam int unsigned DEC_W   = $clog2(DEC_MOD);

endpackage

// File: rtl/decade_stage.sv
// One synchronous mod-DEC_MOD counter; carry is combinational so stages chain within a cycle.
module decade_stage
  import clk_div_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic carry
);

  logic [DEC_W-1:0] count_q, count_d;
  logic             at_max_c;

  assign at_max_c = (count_q == DEC_W'(DEC_MOD - 1));
  assign carry    = inc & at_max_c;

  // Next count: clear wins, otherwise advance and roll over at the modulus.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = at_max_c ? '0 : count_q + DEC_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/prog_clk_divider.sv
// Programmable divider: base tick, square wave and cascaded decade ticks,
// with a pending divisor that only takes effect on a period boundary.
module prog_clk_divider
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DIV_DEFAULT = clk_div_pkg::DIV_DEFAULT,
  parameter int unsigned NDEC        = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
  output logic             tick,
  output logic             sq_out,
  output logic [NDEC-1:0]  dec_tick,
  output logic [CNT_W-1:0] div_cur,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic [NDEC-1:0]  dec_tick_q, dec_tick_d;
  logic             wrap_c;
  logic [NDEC-1:0]  carry_c;

  // Last enabled cycle of the period (div_cur is never zero).
  assign wrap_c = en & ~sync_clr & (cnt_q >= div_cur_q - CNT_W'(1));

  // Decade cascade: stage 0 advances on each wrap, later stages on the previous carry.
  for (genvar k = 0; k < NDEC; k++) begin : g_dec
    logic inc_c;
    if (k == 0) begin : g_first
      assign inc_c = wrap_c;
    end else begin : g_next
      assign inc_c = carry_c[k-1];
    end
    decade_stage u_stage (
      .clk   (clk),
      .reset (reset),
      .inc   (inc_c),
      .clr   (sync_clr),
      .carry (carry_c[k])
    );
  end

  // Next-state for count, divisor pair and registered outputs.
  always_comb begin
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    div_pend_d = div_pend_q;
    tick_d     = 1'b0;
    sq_d       = sq_q;
    dec_tick_d = '0;

    // Zero divisors are meaningless and are dropped.
    if (div_load && (div_val != '0)) begin
      div_pend_d = div_val;
    end

    // The pending value used below is the one held before this cycle's load,
    // so a load coincident with a wrap or clear lands one period later.
    if (sync_clr) begin
      cnt_d     = '0;
      div_cur_d = div_pend_q;
      sq_d      = 1'b0;
    end else if (en) begin
      if (wrap_c) begin
        cnt_d     = '0;
        div_cur_d = div_pend_q;
        tick_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      sq_d       = (cnt_d < (div_cur_d >> 1));
      dec_tick_d = carry_c;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      div_cur_q  <= CNT_W'(DIV_DEFAULT);
      div_pend_q <= CNT_W'(DIV_DEFAULT);
      tick_q     <= 1'b0;
      sq_q       <= 1'b0;
      dec_tick_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      div_pend_q <= div_pend_d;
      tick_q     <= tick_d;
      sq_q       <= sq_d;
      dec_tick_q <= dec_tick_d;
    end
  end

  assign tick     = tick_q;
  assign sq_out   = sq_q;
  assign dec_tick = dec_tick_q;
  assign div_cur  = div_cur_q;
  assign cnt      = cnt_q;

endmodule
